// File: rtl/core_bus_arbiter.sv
// core_bus_arbiter
// Shares the single core bus master port between the instruction-fetch port and
// the data (load/store) port. Each port can hold one outstanding request. The bus
// is granted by priority (data first) with an anti-starvation streak limit for
// fetches. Bus request fields stay stable from bus_start until bus_ready.
// Completions are routed back combinationally to the owning port, and an
// in-flight fetch can be flushed so that its completion is swallowed.
module core_bus_arbiter #(
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        insn_start,
    input  logic [29:0] insn_addr,
    input  logic        insn_flush,
    output logic        insn_ready,
    output logic [31:0] insn_data_rd,

    input  logic        data_start,
    input  logic        data_write,
    input  logic [29:0] data_addr,
    input  logic [31:0] data_data_wr,
    input  logic [3:0]  data_data_be,
    output logic        data_ready,
    output logic [31:0] data_data_rd,

    output logic        bus_start,
    output logic [29:0] bus_addr,
    output logic        bus_write,
    output logic [31:0] bus_data_wr,
    output logic [3:0]  bus_data_be,
    input  logic        bus_ready,
    input  logic [31:0] bus_data_rd
);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_BUSY_INSN = 2'd1;
    localparam logic [1:0] ST_BUSY_DATA = 2'd2;

    // Streak counter wide enough to hold MAX_DATA_STREAK itself.
    localparam int              SW         = (MAX_DATA_STREAK < 1) ? 1 : $clog2(MAX_DATA_STREAK + 1);
    localparam logic [SW-1:0]   STREAK_MAX = SW'(MAX_DATA_STREAK);
    localparam logic [SW-1:0]   STREAK_ONE = SW'(1);

    // Control state
    logic [1:0]    state;
    logic          pend_insn;
    logic          pend_data;
    logic          drop;
    logic [SW-1:0] streak;

    // Latched request fields for a port that could not be granted immediately
    logic [29:0]   insn_addr_q;
    logic          data_write_q;
    logic [29:0]   data_addr_q;
    logic [31:0]   data_data_wr_q;
    logic [3:0]    data_data_be_q;

    // Decode of the current cycle
    logic busy_insn;
    logic busy_data;
    logic done;
    logic insn_in_flight;
    logic data_in_flight;
    logic insn_accept;
    logic data_accept;
    logic insn_cand;
    logic data_cand;
    logic can_grant;
    logic streak_full;
    logic grant_insn;
    logic grant_data;

    // Request acceptance, candidate set and arbitration decision for this edge.
    always_comb begin
        busy_insn      = (state == ST_BUSY_INSN);
        busy_data      = (state == ST_BUSY_DATA);
        done           = (busy_insn | busy_data) & bus_ready;

        // A port stops being "in flight" in the cycle its completion arrives,
        // so a new start in that cycle can be granted back-to-back. A flushed
        // fetch no longer blocks the fetch port.
        insn_in_flight = busy_insn & ~bus_ready & ~drop;
        data_in_flight = busy_data & ~bus_ready;

        // Flush retires the older fetch, so a start alongside it is always taken.
        insn_accept    = insn_start & (insn_flush | (~pend_insn & ~insn_in_flight));
        data_accept    = data_start & ~pend_data & ~data_in_flight;

        // Start pulses bypass the pending registers.
        insn_cand      = (pend_insn & ~insn_flush) | insn_accept;
        data_cand      = pend_data | data_accept;

        can_grant      = (state == ST_IDLE) | done;
        streak_full    = (streak == STREAK_MAX);

        grant_insn     = can_grant & insn_cand & (~data_cand | streak_full);
        grant_data     = can_grant & data_cand & ~grant_insn;
    end

    // Completion routing back to the owning port; read data is zero when not ready.
    always_comb begin
        insn_ready   = busy_insn & bus_ready & ~drop & ~insn_flush;
        data_ready   = busy_data & bus_ready;
        insn_data_rd = insn_ready ? bus_data_rd : 32'd0;
        data_data_rd = data_ready ? bus_data_rd : 32'd0;
    end

    // Capture request fields of accepted starts; only read while the port is pending.
    always_ff @(posedge clk) begin
        if (insn_accept) begin
            insn_addr_q <= insn_addr;
        end
        if (data_accept) begin
            data_write_q   <= data_write;
            data_addr_q    <= data_addr;
            data_data_wr_q <= data_data_wr;
            data_data_be_q <= data_data_be;
        end
    end

    // FSM, pending flags, anti-starvation streak and flush drop flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            pend_insn <= 1'b0;
            pend_data <= 1'b0;
            drop      <= 1'b0;
            streak    <= '0;
        end else begin
            if (grant_insn) begin
                state <= ST_BUSY_INSN;
            end else if (grant_data) begin
                state <= ST_BUSY_DATA;
            end else if (done) begin
                state <= ST_IDLE;
            end

            if (grant_insn) begin
                pend_insn <= 1'b0;
            end else if (insn_accept) begin
                pend_insn <= 1'b1;
            end else if (insn_flush) begin
                pend_insn <= 1'b0;
            end

            if (grant_data) begin
                pend_data <= 1'b0;
            end else if (data_accept) begin
                pend_data <= 1'b1;
            end

            if (grant_insn || !insn_cand) begin
                streak <= '0;
            end else if (grant_data && !streak_full) begin
                streak <= streak + STREAK_ONE;
            end

            // The completion edge of a fetch always retires the drop flag.
            if (busy_insn && bus_ready) begin
                drop <= 1'b0;
            end else if (busy_insn && insn_flush) begin
                drop <= 1'b1;
            end
        end
    end

    // Bus request register: loaded on a grant, held until the next grant.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus_start   <= 1'b0;
            bus_addr    <= 30'd0;
            bus_write   <= 1'b0;
            bus_data_wr <= 32'd0;
            bus_data_be <= 4'd0;
        end else begin
            bus_start <= grant_insn | grant_data;
            if (grant_insn) begin
                bus_addr    <= insn_accept ? insn_addr : insn_addr_q;
                bus_write   <= 1'b0;
                bus_data_wr <= 32'd0;
                bus_data_be <= 4'b1111;
            end else if (grant_data) begin
                bus_addr    <= data_accept ? data_addr    : data_addr_q;
                bus_write   <= data_accept ? data_write   : data_write_q;
                bus_data_wr <= data_accept ? data_data_wr : data_data_wr_q;
                bus_data_be <= data_accept ? data_data_be : data_data_be_q;
            end
        end
    end

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Directed testbench for core_bus_arbiter.
module tb_core_bus_arbiter;

    logic        clk;
    logic        rst_n;
    logic        insn_start;
    logic [29:0] insn_addr;
    logic        insn_flush;
    logic        insn_ready;
    logic [31:0] insn_data_rd;
    logic        data_start;
    logic        data_write;
    logic [29:0] data_addr;
    logic [31:0] data_data_wr;
    logic [3:0]  data_data_be;
    logic        data_ready;
    logic [31:0] data_data_rd;
    logic        bus_start;
    logic [29:0] bus_addr;
    logic        bus_write;
    logic [31:0] bus_data_wr;
    logic [3:0]  bus_data_be;
    logic        bus_ready;
    logic [31:0] bus_data_rd;

    int nvec;
    int nerr;

    core_bus_arbiter #(.MAX_DATA_STREAK(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .insn_start   (insn_start),
        .insn_addr    (insn_addr),
        .insn_flush   (insn_flush),
        .insn_ready   (insn_ready),
        .insn_data_rd (insn_data_rd),
        .data_start   (data_start),
        .data_write   (data_write),
        .data_addr    (data_addr),
        .data_data_wr (data_data_wr),
        .data_data_be (data_data_be),
        .data_ready   (data_ready),
        .data_data_rd (data_data_rd),
        .bus_start    (bus_start),
        .bus_addr     (bus_addr),
        .bus_write    (bus_write),
        .bus_data_wr  (bus_data_wr),
        .bus_data_be  (bus_data_be),
        .bus_ready    (bus_ready),
        .bus_data_rd  (bus_data_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs are changed at edge+1.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_pulses();
        insn_start = 1'b0;
        insn_flush = 1'b0;
        data_start = 1'b0;
        bus_ready  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        nvec++; if (bus_start !== 1'b0) begin nerr++; $display("FAIL rst_bus_start: got %h want 0", bus_start); end
        nvec++; if (bus_addr !== 30'd0) begin nerr++; $display("FAIL rst_bus_addr: got %h want 0", bus_addr); end
        nvec++; if (bus_data_be !== 4'd0) begin nerr++; $display("FAIL rst_bus_be: got %h want 0", bus_data_be); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_load();
        data_start = 1'b1; data_write = 1'b0; data_addr = 30'h100;
        data_data_wr = 32'h0; data_data_be = 4'b1111;
        tick();
        clear_pulses();
        nvec++; if (bus_start !== 1'b1) begin nerr++; $display("FAIL load_bus_start: got %h want 1", bus_start); end
        nvec++; if (bus_addr !== 30'h100) begin nerr++; $display("FAIL load_bus_addr: got %h want 100", bus_addr); end
        nvec++; if (bus_write !== 1'b0) begin nerr++; $display("FAIL load_bus_write: got %h want 0", bus_write); end
        tick();
        nvec++; if (bus_start !== 1'b0) begin nerr++; $display("FAIL load_start_pulse: got %h want 0", bus_start); end
        nvec++; if (bus_addr !== 30'h100) begin nerr++; $display("FAIL load_addr_hold: got %h want 100", bus_addr); end
        bus_ready = 1'b1; bus_data_rd = 32'hDEADBEEF;
        #1;
        nvec++; if (data_ready !== 1'b1) begin nerr++; $display("FAIL load_data_ready: got %h want 1", data_ready); end
        nvec++; if (data_data_rd !== 32'hDEADBEEF) begin nerr++; $display("FAIL load_data_rd: got %h want deadbeef", data_data_rd); end
        nvec++; if (insn_ready !== 1'b0) begin nerr++; $display("FAIL load_insn_ready: got %h want 0", insn_ready); end
        tick();
        clear_pulses();
        nvec++; if (data_data_rd !== 32'd0) begin nerr++; $display("FAIL load_rd_gated: got %h want 0", data_data_rd); end
        nvec++; if (bus_start !== 1'b0) begin nerr++; $display("FAIL load_idle_after: got %h want 0", bus_start); end
    endtask

    task automatic test_simultaneous();
        insn_start = 1'b1; insn_addr = 30'h40;
        data_start = 1'b1; data_write = 1'b1; data_addr = 30'h80;
        data_data_wr = 32'h12345678; data_data_be = 4'b0011;
        tick();
        clear_pulses();
        nvec++; if (bus_start !== 1'b1) begin nerr++; $display("FAIL simul_data_start: got %h want 1", bus_start); end
        nvec++; if (bus_addr !== 30'h80) begin nerr++; $display("FAIL simul_data_addr: got %h want 80", bus_addr); end
        nvec++; if (bus_write !== 1'b1) begin nerr++; $display("FAIL simul_data_write: got %h want 1", bus_write); end
        nvec++; if (bus_data_be !== 4'b0011) begin nerr++; $display("FAIL simul_data_be: got %h want 3", bus_data_be); end
        nvec++; if (bus_data_wr !== 32'h12345678) begin nerr++; $display("FAIL simul_data_wr: got %h want 12345678", bus_data_wr); end
        tick();
        bus_ready = 1'b1; bus_data_rd = 32'h0;
        #1;
        nvec++; if (data_ready !== 1'b1) begin nerr++; $display("FAIL simul_data_ready: got %h want 1", data_ready); end
        nvec++; if (insn_ready !== 1'b0) begin nerr++; $display("FAIL simul_insn_not_ready: got %h want 0", insn_ready); end
        tick();
        clear_pulses();
        nvec++; if (bus_start !== 1'b1) begin nerr++; $display("FAIL simul_insn_start: got %h want 1", bus_start); end
        nvec++; if (bus_addr !== 30'h40) begin nerr++; $display("FAIL simul_insn_addr: got %h want 40", bus_addr); end
        nvec++; if (bus_write !== 1'b0) begin nerr++; $display("FAIL simul_insn_write: got %h want 0", bus_write); end
        nvec++; if (bus_data_wr !== 32'd0) begin nerr++; $display("FAIL simul_insn_wr: got %h want 0", bus_data_wr); end
        nvec++; if (bus_data_be !== 4'b1111) begin nerr++; $display("FAIL simul_insn_be: got %h want f", bus_data_be); end
        tick();
        bus_ready = 1'b1; bus_data_rd = 32'hCAFEF00D;
        #1;
        nvec++; if (insn_ready !== 1'b1) begin nerr++; $display("FAIL simul_insn_ready: got %h want 1", insn_ready); end
        nvec++; if (insn_data_rd !== 32'hCAFEF00D) begin nerr++; $display("FAIL simul_insn_rd: got %h want cafef00d", insn_data_rd); end
        nvec++; if (data_ready !== 1'b0) begin nerr++; $display("FAIL simul_data_quiet: got %h want 0", data_ready); end
        tick();
        clear_pulses();
    endtask

    task automatic test_starvation();
        insn_start = 1'b1; insn_addr = 30'h48;
        data_start = 1'b1; data_write = 1'b0; data_addr = 30'h200;
        data_data_wr = 32'h0; data_data_be = 4'b1111;
        tick();
        clear_pulses();
        for (int k = 0; k < 4; k++) begin
            nvec++; if (bus_start !== 1'b1) begin nerr++; $display("FAIL starve_data_start%0d: got %h want 1", k, bus_start); end
            nvec++; if (bus_addr !== 30'(30'h200 + k)) begin nerr++; $display("FAIL starve_data_addr%0d: got %h want %h", k, bus_addr, 30'(30'h200 + k)); end
            tick();
            bus_ready = 1'b1; bus_data_rd = 32'h0;
            data_start = 1'b1; data_addr = 30'(30'h200 + k + 1);
            tick();
            clear_pulses();
        end
        nvec++; if (bus_start !== 1'b1) begin nerr++; $display("FAIL starve_insn_start: got %h want 1", bus_start); end
        nvec++; if (bus_addr !== 30'h48) begin nerr++; $display("FAIL starve_insn_addr: got %h want 48", bus_addr); end
        tick();
        bus_ready = 1'b1; bus_data_rd = 32'h0BADF00D;
        #1;
        nvec++; if (insn_ready !== 1'b1) begin nerr++; $display("FAIL starve_insn_ready: got %h want 1", insn_ready); end
        tick();
        clear_pulses();
        nvec++; if (bus_start !== 1'b1) begin nerr++; $display("FAIL starve_pend_data_start: got %h want 1", bus_start); end
        nvec++; if (bus_addr !== 30'h204) begin nerr++; $display("FAIL starve_pend_data_addr: got %h want 204", bus_addr); end
        tick();
        bus_ready = 1'b1;
        tick();
        clear_pulses();
    endtask

    task automatic test_flush();
        insn_start = 1'b1; insn_addr = 30'h60;
        tick();
        clear_pulses();
        nvec++; if (bus_addr !== 30'h60) begin nerr++; $display("FAIL flush_issue_addr: got %h want 60", bus_addr); end
        tick();
        insn_flush = 1'b1;
        tick();
        clear_pulses();
        bus_ready = 1'b1; bus_data_rd = 32'h11112222;
        #1;
        nvec++; if (insn_ready !== 1'b0) begin nerr++; $display("FAIL flush_ready_dropped: got %h want 0", insn_ready); end
        nvec++; if (insn_data_rd !== 32'd0) begin nerr++; $display("FAIL flush_rd_dropped: got %h want 0", insn_data_rd); end
        tick();
        clear_pulses();
        nvec++; if (bus_start !== 1'b0) begin nerr++; $display("FAIL flush_no_reissue: got %h want 0", bus_start); end
        insn_start = 1'b1; insn_addr = 30'h44;
        tick();
        clear_pulses();
        nvec++; if (bus_start !== 1'b1) begin nerr++; $display("FAIL flush_next_start: got %h want 1", bus_start); end
        nvec++; if (bus_addr !== 30'h44) begin nerr++; $display("FAIL flush_next_addr: got %h want 44", bus_addr); end
        tick();
        bus_ready = 1'b1; bus_data_rd = 32'h44444444;
        #1;
        nvec++; if (insn_ready !== 1'b1) begin nerr++; $display("FAIL flush_next_ready: got %h want 1", insn_ready); end
        nvec++; if (insn_data_rd !== 32'h44444444) begin nerr++; $display("FAIL flush_next_rd: got %h want 44444444", insn_data_rd); end
        tick();
        clear_pulses();
        // Flush arriving together with the completion.
        insn_start = 1'b1; insn_addr = 30'h50;
        tick();
        clear_pulses();
        tick();
        bus_ready = 1'b1; insn_flush = 1'b1; bus_data_rd = 32'h55555555;
        #1;
        nvec++; if (insn_ready !== 1'b0) begin nerr++; $display("FAIL flush_same_cycle: got %h want 0", insn_ready); end
        tick();
        clear_pulses();
        insn_start = 1'b1; insn_addr = 30'h54;
        tick();
        clear_pulses();
        tick();
        bus_ready = 1'b1; bus_data_rd = 32'h66666666;
        #1;
        nvec++; if (insn_ready !== 1'b1) begin nerr++; $display("FAIL flush_drop_cleared: got %h want 1", insn_ready); end
        tick();
        clear_pulses();
    endtask

    task automatic test_duplicate();
        data_start = 1'b1; data_write = 1'b0; data_addr = 30'h300;
        tick();
        clear_pulses();
        nvec++; if (bus_start !== 1'b1) begin nerr++; $display("FAIL dup_first_start: got %h want 1", bus_start); end
        data_start = 1'b1; data_addr = 30'h304;
        tick();
        clear_pulses();
        nvec++; if (bus_start !== 1'b0) begin nerr++; $display("FAIL dup_no_start: got %h want 0", bus_start); end
        nvec++; if (bus_addr !== 30'h300) begin nerr++; $display("FAIL dup_addr_hold: got %h want 300", bus_addr); end
        bus_ready = 1'b1; bus_data_rd = 32'h0;
        tick();
        clear_pulses();
        for (int k = 0; k < 3; k++) begin
            nvec++; if (bus_start !== 1'b0) begin nerr++; $display("FAIL dup_quiet%0d: got %h want 0", k, bus_start); end
            tick();
        end
    endtask

    task automatic test_reset_mid_busy();
        data_start = 1'b1; data_write = 1'b1; data_addr = 30'h180;
        data_data_wr = 32'hA5A5A5A5; data_data_be = 4'b1100;
        tick();
        clear_pulses();
        nvec++; if (bus_addr !== 30'h180) begin nerr++; $display("FAIL rstmid_issue_addr: got %h want 180", bus_addr); end
        tick();
        rst_n = 1'b0;
        tick();
        tick();
        tick();
        nvec++; if (bus_start !== 1'b0) begin nerr++; $display("FAIL rstmid_bus_start: got %h want 0", bus_start); end
        nvec++; if (bus_addr !== 30'd0) begin nerr++; $display("FAIL rstmid_bus_addr: got %h want 0", bus_addr); end
        nvec++; if (bus_write !== 1'b0) begin nerr++; $display("FAIL rstmid_bus_write: got %h want 0", bus_write); end
        nvec++; if (bus_data_wr !== 32'd0) begin nerr++; $display("FAIL rstmid_bus_wr: got %h want 0", bus_data_wr); end
        nvec++; if (bus_data_be !== 4'd0) begin nerr++; $display("FAIL rstmid_bus_be: got %h want 0", bus_data_be); end
        rst_n = 1'b1;
        tick();
        bus_ready = 1'b1; bus_data_rd = 32'h77777777;
        #1;
        nvec++; if (data_ready !== 1'b0) begin nerr++; $display("FAIL rstmid_ready_ignored: got %h want 0", data_ready); end
        nvec++; if (data_data_rd !== 32'd0) begin nerr++; $display("FAIL rstmid_rd_ignored: got %h want 0", data_data_rd); end
        nvec++; if (insn_ready !== 1'b0) begin nerr++; $display("FAIL rstmid_insn_ignored: got %h want 0", insn_ready); end
        tick();
        clear_pulses();
        nvec++; if (bus_start !== 1'b0) begin nerr++; $display("FAIL rstmid_no_start: got %h want 0", bus_start); end
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        rst_n        = 1'b0;
        insn_start   = 1'b0;
        insn_addr    = 30'd0;
        insn_flush   = 1'b0;
        data_start   = 1'b0;
        data_write   = 1'b0;
        data_addr    = 30'd0;
        data_data_wr = 32'd0;
        data_data_be = 4'd0;
        bus_ready    = 1'b0;
        bus_data_rd  = 32'd0;
        #1;
        test_reset();
        test_single_load();
        test_simultaneous();
        test_starvation();
        test_flush();
        test_duplicate();
        test_reset_mid_busy();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
